seq_reco: RTL and testbench



---
 rtl/seq_reco.sv | 68 ++++++
 tb/tb_seq_reco.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seq_reco.sv
// Sequential recorrelator for two unipolar stochastic bitstreams.
// Holds back one unmatched 1 and releases it against the next opposite mismatch.
module seq_reco (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    input  logic y,
    output logic x_reco_r,
    output logic y_reco_r
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HX   = 2'd1;
    localparam logic [1:0] HY   = 2'd2;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       x_next;
    logic       y_next;

    always_comb begin
        next_state = state;
        x_next     = x;
        y_next     = y;
        case (state)
            IDLE: begin
                if (x && !y) begin
                    next_state = HX;
                    x_next     = 1'b0;
                    y_next     = 1'b0;
                end else if (!x && y) begin
                    next_state = HY;
                    x_next     = 1'b0;
                    y_next     = 1'b0;
                end
            end
            HX: begin
                if (!x && y) begin
                    next_state = IDLE;
                    x_next     = 1'b1;
                    y_next     = 1'b1;
                end
            end
            HY: begin
                if (x && !y) begin
                    next_state = IDLE;
                    x_next     = 1'b1;
                    y_next     = 1'b1;
                end
            end
            // Unused encoding recovers to IDLE without inventing a held bit.
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            x_reco_r <= 1'b0;
            y_reco_r <= 1'b0;
        end else begin
            state    <= next_state;
            x_reco_r <= x_next;
            y_reco_r <= y_next;
        end
    end

endmodule

// File: tb/tb_seq_reco.sv
// Self-checking bench for seq_reco: directed cases plus random streams
// checked against a signed-pending-bit reference model.
module tb_seq_reco;

    logic clk = 1'b0;
    logic rst_n;
    logic x;
    logic y;
    logic x_reco_r;
    logic y_reco_r;

    int tests_run = 0;
    int tests_failed = 0;

    // +1 when an X one is pending, -1 when a Y one is pending, 0 otherwise.
    int pend = 0;

    seq_reco dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x),
        .y        (y),
        .x_reco_r (x_reco_r),
        .y_reco_r (y_reco_r)
    );

    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic xv, input logic yv, input logic rv);
        rst_n = rv;
        x     = xv;
        y     = yv;
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic ex, input logic ey);
        tests_run++;
        assert ({x_reco_r, y_reco_r} === {ex, ey})
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: got x=%b y=%b, expected x=%b y=%b",
                   tag, x_reco_r, y_reco_r, ex, ey);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        tests_run++;
        assert (got == want)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Reference model: a mismatch d = x - y either parks a bit, cancels the
    // opposite pending bit as a 1,1 pair, or passes through.
    task automatic model_step(input logic xv, input logic yv, output logic ex, output logic ey);
        int d;
        d = int'(xv) - int'(yv);
        if (d != 0 && pend == 0) begin
            pend = d;
            ex = 1'b0;
            ey = 1'b0;
        end else if (d != 0 && d == -pend) begin
            pend = 0;
            ex = 1'b1;
            ey = 1'b1;
        end else begin
            ex = xv;
            ey = yv;
        end
    endtask

    task automatic do_reset(input logic xv, input logic yv);
        apply_stimulus(xv, yv, 1'b0);
        pend = 0;
    endtask

    initial begin
        logic xs, ys, ex, ey;
        int in_x, in_y, in_and, out_x, out_y, out_and;

        rst_n = 1'b0;
        x     = 1'b0;
        y     = 1'b0;
        @(negedge clk);
        do_reset(1'b1, 1'b0);
        check_output("reset", 1'b0, 1'b0);

        // x=1,1,0,0 / y=1,0,0,1
        apply_stimulus(1, 1, 1); check_output("t1_0", 1, 1);
        apply_stimulus(1, 0, 1); check_output("t1_1", 0, 0);
        apply_stimulus(0, 0, 1); check_output("t1_2", 0, 0);
        apply_stimulus(0, 1, 1); check_output("t1_3", 1, 1);

        // x=1,0,0,1 / y=1,1,1,0
        do_reset(0, 0); check_output("t2_rst", 0, 0);
        apply_stimulus(1, 1, 1); check_output("t2_0", 1, 1);
        apply_stimulus(0, 1, 1); check_output("t2_1", 0, 0);
        apply_stimulus(0, 1, 1); check_output("t2_2", 0, 1);
        apply_stimulus(1, 0, 1); check_output("t2_3", 1, 1);

        // x=1,1,1 / y=0,0,1: no release on equal pair
        do_reset(0, 0); check_output("t3_rst", 0, 0);
        apply_stimulus(1, 0, 1); check_output("t3_0", 0, 0);
        apply_stimulus(1, 0, 1); check_output("t3_1", 1, 0);
        apply_stimulus(1, 1, 1); check_output("t3_2", 1, 1);

        // Reset while holding Y, inputs during reset ignored
        do_reset(0, 0); check_output("t4_rst", 0, 0);
        apply_stimulus(0, 1, 1); check_output("t4_hold", 0, 0);
        do_reset(1, 0);          check_output("t4_midrst", 0, 0);
        apply_stimulus(1, 0, 1); check_output("t4_absorb", 0, 0);
        apply_stimulus(0, 1, 1); check_output("t4_release", 1, 1);

        // 256-bit random streams from IDLE
        do_reset(0, 0); check_output("rnd_rst", 0, 0);
        in_x = 0; in_y = 0; in_and = 0; out_x = 0; out_y = 0; out_and = 0;
        for (int i = 0; i < 256; i++) begin
            xs = 1'($urandom_range(0, 1));
            ys = 1'($urandom_range(0, 1));
            model_step(xs, ys, ex, ey);
            apply_stimulus(xs, ys, 1);
            check_output($sformatf("rnd_%0d", i), ex, ey);
            in_x    += int'(xs);
            in_y    += int'(ys);
            in_and  += int'(xs & ys);
            out_x   += int'(x_reco_r);
            out_y   += int'(y_reco_r);
            out_and += int'(x_reco_r & y_reco_r);
        end
        check_int("ones_x", out_x, in_x - ((pend > 0) ? 1 : 0));
        check_int("ones_y", out_y, in_y - ((pend < 0) ? 1 : 0));
        check_int("and_not_lower", int'(out_and >= in_and), 1);

        // Equal streams pass through unchanged
        do_reset(0, 0); check_output("eq_rst", 0, 0);
        for (int i = 0; i < 32; i++) begin
            xs = 1'($urandom_range(0, 1));
            apply_stimulus(xs, xs, 1);
            check_output($sformatf("eq_%0d", i), xs, xs);
        end
        // An odd mismatch afterwards must still be absorbed, proving IDLE held.
        apply_stimulus(1, 0, 1); check_output("eq_idle", 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
